// File: rtl/fifo_ptr_pkg.sv
// rtl/fifo_ptr_pkg.sv - shared types and Gray/binary helpers for FIFO pointer logic
package fifo_ptr_pkg;

    typedef enum logic {
        SIDE_RD = 1'b0,
        SIDE_WR = 1'b1
    } fifo_side_e;

    localparam int DEF_ADDR_W = 4;

    // Helpers operate on a 32-bit container; zero-extended operands give the
    // correct result for any narrower pointer once truncated back.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_sync.sv
// rtl/gray_sync.sv - multi-flop synchroniser for a Gray-coded bus
module gray_sync #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/gray_fifo_ptr.sv
// rtl/gray_fifo_ptr.sv - one-side async FIFO pointer engine with full/empty, level and almost flags
module gray_fifo_ptr
    import fifo_ptr_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int IS_WR       = 1,
    parameter int ALMOST_TH   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic [ADDR_W:0]   remote_gray,
    output logic [ADDR_W:0]   ptr_bin,
    output logic [ADDR_W:0]   ptr_gray,
    output logic [ADDR_W-1:0] addr,
    output logic              flag,
    output logic              almost,
    output logic [ADDR_W:0]   level
);

    localparam int PTR_W = ADDR_W + 1;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam fifo_side_e SIDE = (IS_WR != 0) ? SIDE_WR : SIDE_RD;
    localparam logic FLAG_RST = (SIDE == SIDE_RD);

    logic [PTR_W-1:0] rsync;
    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] next_bin;
    logic [PTR_W-1:0] next_gray;
    logic [PTR_W-1:0] full_pat;
    logic [PTR_W-1:0] level_n;
    logic             accept;
    logic             flag_n;
    logic             almost_n;

    gray_sync #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (remote_gray),
        .q   (rsync)
    );

    // Flags compare the next local pointer against the synchronised remote one,
    // so a local accept and a remote update land in the same decision.
    always_comb begin
        accept    = inc & ~flag;
        next_bin  = ptr_bin + PTR_W'(accept);
        next_gray = PTR_W'(bin2gray(32'(next_bin)));
        rbin      = PTR_W'(gray2bin(32'(rsync)));
        full_pat  = {~rsync[PTR_W-1:PTR_W-2], rsync[PTR_W-3:0]};
        if (SIDE == SIDE_WR) begin
            flag_n   = (next_gray == full_pat);
            level_n  = next_bin - rbin;
            almost_n = (32'(level_n) >= 32'(DEPTH - ALMOST_TH));
        end else begin
            flag_n   = (next_gray == rsync);
            level_n  = rbin - next_bin;
            almost_n = (32'(level_n) <= 32'(ALMOST_TH));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_bin  <= '0;
            ptr_gray <= '0;
            level    <= '0;
            flag     <= FLAG_RST;
            almost   <= FLAG_RST;
        end else begin
            ptr_bin  <= next_bin;
            ptr_gray <= next_gray;
            level    <= level_n;
            flag     <= flag_n;
            almost   <= almost_n;
        end
    end

    assign addr = ptr_bin[ADDR_W-1:0];

endmodule

// File: tb/tb_gray_fifo_ptr.sv
// tb/tb_gray_fifo_ptr.sv - scoreboard bench for write- and read-side gray_fifo_ptr instances
module tb_gray_fifo_ptr;

    logic       clk = 1'b0;
    logic       rst_wr, rst_rd, inc_wr, inc_rd;
    logic [3:0] rg_wr, rg_rd;
    logic [3:0] wr_bin, wr_gray, wr_level, rd_bin, rd_gray, rd_level;
    logic [2:0] wr_addr, rd_addr;
    logic       wr_flag, wr_almost, rd_flag, rd_almost;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0] bin;
        logic [3:0] gray;
        logic       flag;
        logic       almost;
        logic [3:0] level;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    gray_fifo_ptr #(.ADDR_W(3), .SYNC_STAGES(2), .IS_WR(1), .ALMOST_TH(2)) u_wr (
        .clk(clk), .rst(rst_wr), .inc(inc_wr), .remote_gray(rg_wr),
        .ptr_bin(wr_bin), .ptr_gray(wr_gray), .addr(wr_addr),
        .flag(wr_flag), .almost(wr_almost), .level(wr_level)
    );

    gray_fifo_ptr #(.ADDR_W(3), .SYNC_STAGES(2), .IS_WR(0), .ALMOST_TH(2)) u_rd (
        .clk(clk), .rst(rst_rd), .inc(inc_rd), .remote_gray(rg_rd),
        .ptr_bin(rd_bin), .ptr_gray(rd_gray), .addr(rd_addr),
        .flag(rd_flag), .almost(rd_almost), .level(rd_level)
    );

    function automatic logic [3:0] g(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic exp_t mk(input logic [3:0] b, input logic f, input logic a, input logic [3:0] l);
        exp_t e;
        e.bin = b; e.gray = g(b); e.flag = f; e.almost = a; e.level = l;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        rg_wr = '0; rg_rd = '0; inc_wr = 1'b0; inc_rd = 1'b0;
        rst_wr = 1'b1; rst_rd = 1'b1;
        sb.push_back(mk(4'd0, 1'b0, 1'b0, 4'd0));
        sb.push_back(mk(4'd0, 1'b1, 1'b1, 4'd0));
        tick();
        rst_wr = 1'b0; rst_rd = 1'b0;
        e = sb.pop_front();
        n_cmp++; if (wr_bin !== e.bin) begin n_bad++; $display("FAIL reset.wr_bin got %0d want %0d", wr_bin, e.bin); end
        n_cmp++; if (wr_gray !== e.gray) begin n_bad++; $display("FAIL reset.wr_gray got %b want %b", wr_gray, e.gray); end
        n_cmp++; if ({wr_flag, wr_almost} !== {e.flag, e.almost}) begin n_bad++; $display("FAIL reset.wr_flags got %b%b want %b%b", wr_flag, wr_almost, e.flag, e.almost); end
        n_cmp++; if (wr_level !== e.level) begin n_bad++; $display("FAIL reset.wr_level got %0d want %0d", wr_level, e.level); end
        e = sb.pop_front();
        n_cmp++; if (rd_bin !== e.bin || rd_gray !== e.gray) begin n_bad++; $display("FAIL reset.rd_ptr got %0d/%b want %0d/%b", rd_bin, rd_gray, e.bin, e.gray); end
        n_cmp++; if ({rd_flag, rd_almost} !== {e.flag, e.almost}) begin n_bad++; $display("FAIL reset.rd_flags got %b%b want %b%b", rd_flag, rd_almost, e.flag, e.almost); end
        n_cmp++; if (rd_level !== e.level) begin n_bad++; $display("FAIL reset.rd_level got %0d want %0d", rd_level, e.level); end
    endtask

    task automatic test_wr_fill();
        exp_t e;
        rg_wr = '0; rst_wr = 1'b1; tick(); rst_wr = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            logic [3:0] b;
            b = (k > 8) ? 4'd8 : 4'(k);
            inc_wr = 1'b1;
            sb.push_back(mk(b, b == 4'd8, b >= 4'd6, b));
            tick();
            e = sb.pop_front();
            n_cmp++; if (wr_bin !== e.bin || wr_gray !== e.gray) begin n_bad++; $display("FAIL fill.ptr[%0d] got %0d/%b want %0d/%b", k, wr_bin, wr_gray, e.bin, e.gray); end
            n_cmp++; if (wr_flag !== e.flag || wr_almost !== e.almost) begin n_bad++; $display("FAIL fill.flags[%0d] got %b%b want %b%b", k, wr_flag, wr_almost, e.flag, e.almost); end
            n_cmp++; if (wr_level !== e.level) begin n_bad++; $display("FAIL fill.level[%0d] got %0d want %0d", k, wr_level, e.level); end
        end
        inc_wr = 1'b0;
    endtask

    task automatic test_wr_drain();
        exp_t e;
        rg_wr = 4'b0001;
        for (int k = 1; k <= 3; k++) begin
            sb.push_back(mk(4'd8, k < 3, 1'b1, (k < 3) ? 4'd8 : 4'd7));
            tick();
            e = sb.pop_front();
            n_cmp++; if (wr_bin !== e.bin || wr_gray !== e.gray) begin n_bad++; $display("FAIL drain.ptr[%0d] got %0d/%b want %0d/%b", k, wr_bin, wr_gray, e.bin, e.gray); end
            n_cmp++; if (wr_flag !== e.flag || wr_almost !== e.almost) begin n_bad++; $display("FAIL drain.flags[%0d] got %b%b want %b%b", k, wr_flag, wr_almost, e.flag, e.almost); end
            n_cmp++; if (wr_level !== e.level) begin n_bad++; $display("FAIL drain.level[%0d] got %0d want %0d", k, wr_level, e.level); end
        end
    endtask

    task automatic test_rd_start();
        exp_t e;
        rg_rd = 4'b0010;
        for (int k = 1; k <= 7; k++) begin
            inc_rd = (k >= 4);
            case (k)
                1, 2:    sb.push_back(mk(4'd0, 1'b1, 1'b1, 4'd0));
                3:       sb.push_back(mk(4'd0, 1'b0, 1'b0, 4'd3));
                4:       sb.push_back(mk(4'd1, 1'b0, 1'b1, 4'd2));
                5:       sb.push_back(mk(4'd2, 1'b0, 1'b1, 4'd1));
                default: sb.push_back(mk(4'd3, 1'b1, 1'b1, 4'd0));
            endcase
            tick();
            e = sb.pop_front();
            n_cmp++; if (rd_bin !== e.bin || rd_gray !== e.gray) begin n_bad++; $display("FAIL rd_start.ptr[%0d] got %0d/%b want %0d/%b", k, rd_bin, rd_gray, e.bin, e.gray); end
            n_cmp++; if (rd_flag !== e.flag || rd_almost !== e.almost) begin n_bad++; $display("FAIL rd_start.flags[%0d] got %b%b want %b%b", k, rd_flag, rd_almost, e.flag, e.almost); end
            n_cmp++; if (rd_level !== e.level) begin n_bad++; $display("FAIL rd_start.level[%0d] got %0d want %0d", k, rd_level, e.level); end
        end
        inc_rd = 1'b0;
    endtask

    // Remote moves to 4 to reach level 1, then to 5; the pop is timed so the
    // compare that sees rsync=5 also sees the accept.
    task automatic test_simultaneous();
        exp_t e;
        for (int k = 1; k <= 7; k++) begin
            if (k == 1) rg_rd = g(4'd4);
            if (k == 4) rg_rd = g(4'd5);
            inc_rd = (k == 6);
            if (k <= 2) sb.push_back(mk(4'd3, 1'b1, 1'b1, 4'd0));
            else if (k <= 5) sb.push_back(mk(4'd3, 1'b0, 1'b1, 4'd1));
            else sb.push_back(mk(4'd4, 1'b0, 1'b1, 4'd1));
            tick();
            e = sb.pop_front();
            n_cmp++; if (rd_bin !== e.bin || rd_addr !== e.bin[2:0]) begin n_bad++; $display("FAIL simul.ptr[%0d] got %0d want %0d", k, rd_bin, e.bin); end
            n_cmp++; if (rd_flag !== e.flag || rd_level !== e.level) begin n_bad++; $display("FAIL simul.state[%0d] got empty=%b level=%0d want empty=%b level=%0d", k, rd_flag, rd_level, e.flag, e.level); end
        end
        inc_rd = 1'b0;
    endtask

    task automatic test_wrap();
        exp_t e;
        logic [3:0] mb = '0;
        logic [3:0] prev;
        logic [3:0] hist[$];
        int acc;
        rg_wr = '0; rst_wr = 1'b1; tick(); rst_wr = 1'b0;
        hist.push_back(4'd0);
        for (int c = 0; c < 25; c++) begin
            inc_wr = (c % 5 != 4);
            acc = inc_wr ? 1 : 0;
            prev = wr_gray;
            mb = mb + 4'(acc);
            sb.push_back(mk(mb, 1'b0, 1'b0, 4'd0));
            tick();
            hist.push_back(g(mb));
            rg_wr = (hist.size() >= 3) ? hist[hist.size()-3] : 4'd0;
            e = sb.pop_front();
            n_cmp++; if (wr_bin !== e.bin || wr_addr !== e.bin[2:0]) begin n_bad++; $display("FAIL wrap.bin[%0d] got %0d want %0d", c, wr_bin, e.bin); end
            n_cmp++; if (wr_gray !== e.gray) begin n_bad++; $display("FAIL wrap.gray[%0d] got %b want %b", c, wr_gray, e.gray); end
            n_cmp++; if ($countones(wr_gray ^ prev) != acc) begin n_bad++; $display("FAIL wrap.toggle[%0d] got %0d bits want %0d", c, $countones(wr_gray ^ prev), acc); end
            n_cmp++; if (wr_flag !== e.flag) begin n_bad++; $display("FAIL wrap.full[%0d] got %b want %b", c, wr_flag, e.flag); end
        end
        inc_wr = 1'b0;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        rg_wr = '0; rst_wr = 1'b1; tick(); rst_wr = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (k <= 5) begin
                inc_wr = 1'b1;
                sb.push_back(mk(4'(k), 1'b0, 1'b0, 4'(k)));
            end else if (k <= 8) begin
                rst_wr = 1'b1; inc_wr = 1'b1; rg_wr = 4'b0001;
                sb.push_back(mk(4'd0, 1'b0, 1'b0, 4'd0));
            end else begin
                rst_wr = 1'b0; inc_wr = 1'b1; rg_wr = 4'b0000;
                sb.push_back(mk(4'(k - 8), 1'b0, (k - 8) >= 6, 4'(k - 8)));
            end
            tick();
            e = sb.pop_front();
            n_cmp++; if (wr_bin !== e.bin || wr_gray !== e.gray) begin n_bad++; $display("FAIL rst_mid.ptr[%0d] got %0d/%b want %0d/%b", k, wr_bin, wr_gray, e.bin, e.gray); end
            n_cmp++; if (wr_flag !== e.flag || wr_almost !== e.almost) begin n_bad++; $display("FAIL rst_mid.flags[%0d] got %b%b want %b%b", k, wr_flag, wr_almost, e.flag, e.almost); end
            n_cmp++; if (wr_level !== e.level) begin n_bad++; $display("FAIL rst_mid.level[%0d] got %0d want %0d", k, wr_level, e.level); end
        end
        inc_wr = 1'b0; rst_wr = 1'b0;
    endtask

    initial begin
        rst_wr = 1'b1; rst_rd = 1'b1; inc_wr = 1'b0; inc_rd = 1'b0;
        rg_wr = '0; rg_rd = '0;
        test_reset();
        test_wr_fill();
        test_wr_drain();
        test_rd_start();
        test_simultaneous();
        test_wrap();
        test_reset_mid();
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL scoreboard.leftover got %0d want 0", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
